// File: rtl/regfile_stream_pkg.sv
// Shared types and the address-step rule for the register-file stream port.
package regfile_stream_pkg;

    // Command sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } rfs_state_t;

    // Command direction carried on cmd_dump.
    typedef enum logic {
        RFS_LOAD = 1'b0,
        RFS_DUMP = 1'b1
    } rfs_mode_t;

    // Next register address: wraps past the top register back to 1, so the
    // hardwired-zero register 0 is never visited.
    function automatic int unsigned rfs_next_addr(input int unsigned ptr,
                                                  input int unsigned depth);
        return (ptr == depth - 1) ? 1 : ptr + 1;
    endfunction

endpackage

// File: rtl/rfs_out_stage.sv
// One-entry valid/ready holding register for the DUMP read path.
// Refills in the same cycle the held word is taken, so a consumer holding
// out_ready high sees one word per cycle.
module rfs_out_stage #(
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            load_en,
    input  logic [BITS-1:0] load_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            can_load
);

    logic            valid_reg;
    logic [BITS-1:0] data_reg;

    // A new word may enter when the slot is empty or is being emptied now.
    assign can_load  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Hold, refill or drain the single slot; data only moves on a load so it
    // stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load_en) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_stream_port.sv
// Sequential initiator for the register-file write port and read port 1.
// LOAD streams input words into consecutive registers; DUMP streams
// consecutive registers out through a one-entry output stage.
module regfile_stream_port
    import regfile_stream_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned BITS  = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    // command channel
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_dump,
    input  logic [AW-1:0]   cmd_base,
    input  logic [AW-1:0]   cmd_count,
    // LOAD data channel
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    // register file write port
    output logic [AW-1:0]   rf_addressw,
    output logic [BITS-1:0] rf_writeData,
    output logic            rf_writeEn,
    // register file read port 1
    output logic [AW-1:0]   rf_address1,
    input  logic [BITS-1:0] rf_read1,
    // DUMP data channel
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    // status
    output logic            busy,
    output logic            done
);

    rfs_state_t    state_reg;
    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] rem_reg;
    logic [AW-1:0] ptr_next;
    rfs_mode_t     cmd_mode;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;
    logic stage_can_load;
    logic stage_load;

    assign cmd_mode = rfs_mode_t'(cmd_dump);
    assign ptr_next = AW'(rfs_next_addr(32'(ptr_reg), DEPTH));

    assign cmd_fire   = cmd_valid && (state_reg == IDLE);
    assign in_fire    = (state_reg == LOAD) && in_valid;
    assign out_fire   = out_valid && out_ready;
    // Fetch the next register whenever words remain and the stage has room.
    assign stage_load = (state_reg == DUMP) && (rem_reg != '0) && stage_can_load;

    // Sequencer: command capture, per-word pointer/count stepping, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= AW'(1);
            rem_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        ptr_reg <= (cmd_base == '0) ? AW'(1) : cmd_base;
                        rem_reg <= cmd_count;
                        if (cmd_count == '0) begin
                            state_reg <= DONE;
                        end else if (cmd_mode == RFS_DUMP) begin
                            state_reg <= DUMP;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        ptr_reg <= ptr_next;
                        rem_reg <= rem_reg - AW'(1);
                        if (rem_reg == AW'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DUMP: begin
                    if (stage_load) begin
                        ptr_reg <= ptr_next;
                        rem_reg <= rem_reg - AW'(1);
                    end
                    // Nothing left to fetch and the last held word leaves now.
                    if (out_fire && (rem_reg == '0)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    rfs_out_stage #(
        .BITS(BITS)
    ) u_out_stage (
        .clk       (clk),
        .srst      (rst),
        .load_en   (stage_load),
        .load_data (rf_read1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .can_load  (stage_can_load)
    );

    // Handshake and status decode from the state register.
    assign cmd_ready = (state_reg == IDLE);
    assign in_ready  = (state_reg == LOAD);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    // Write port is quiet outside LOAD; a reset cycle suppresses the write
    // so an abort takes effect without one more word landing.
    assign rf_writeEn   = in_fire && !rst;
    assign rf_addressw  = (state_reg == LOAD) ? ptr_reg : '0;
    assign rf_writeData = (state_reg == LOAD) ? in_data : '0;
    assign rf_address1  = (state_reg == DUMP) ? ptr_reg : '0;

endmodule

// File: tb/tb_regfile_stream_port.sv
// Scoreboard bench for regfile_stream_port with a behavioural register file.
module tb_regfile_stream_port;

    localparam int DEPTH   = 16;
    localparam int BITS    = 32;
    localparam int AW      = 4;
    localparam int TIMEOUT = 200;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tb_init = 1'b1;
    logic            cmd_valid, cmd_ready, cmd_dump;
    logic [AW-1:0]   cmd_base, cmd_count;
    logic            in_valid, in_ready;
    logic [BITS-1:0] in_data;
    logic [AW-1:0]   rf_addressw, rf_address1;
    logic [BITS-1:0] rf_writeData, rf_read1;
    logic            rf_writeEn;
    logic            out_valid, out_ready;
    logic [BITS-1:0] out_data;
    logic            busy, done;

    always #5 clk = ~clk;

    regfile_stream_port #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dump(cmd_dump),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rf_addressw(rf_addressw), .rf_writeData(rf_writeData), .rf_writeEn(rf_writeEn),
        .rf_address1(rf_address1), .rf_read1(rf_read1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // Register file partner: r0 reads zero, combinational read, clocked write.
    logic [BITS-1:0] rf_mem [DEPTH];
    assign rf_read1 = (rf_address1 == '0) ? '0 : rf_mem[rf_address1];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= 32'hC0DE_0000 + i;
        end else if (rf_writeEn && rf_addressw != '0) begin
            rf_mem[rf_addressw] <= rf_writeData;
        end
    end

    // Reference contents and expected-response queues.
    logic [BITS-1:0] model_mem [DEPTH];
    typedef struct packed { logic [AW-1:0] addr; logic [BITS-1:0] data; } wr_t;
    wr_t             wr_q [$];
    logic [BITS-1:0] rd_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, wen_cnt = 0, ovalid_cnt = 0, hs_cnt = 0;
    bit mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register visited by word i of a command: start at base (0 means 1),
    // walk upward through 1..DEPTH-1 cyclically.
    function automatic int addr_of(input int base, input int i);
        int start;
        start = (base == 0) ? 1 : base;
        return ((start - 1 + i) % (DEPTH - 1)) + 1;
    endfunction

    // Monitor: pops expectations on every write and every output handshake,
    // and checks stability across output stalls.
    initial begin
        wr_t             w;
        logic            prev_stall;
        logic [BITS-1:0] prev_data;
        logic [AW-1:0]   prev_addr;
        prev_stall = 0; prev_data = '0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rf_writeEn) begin
                    wen_cnt++;
                    check("write_expected", 32'(wr_q.size() != 0), 1);
                    if (wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        check("write_addr", 32'(rf_addressw), 32'(w.addr));
                        check("write_data", rf_writeData, w.data);
                    end
                end
                if (out_valid) ovalid_cnt++;
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_addr1", 32'(rf_address1), 32'(prev_addr));
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    check("dump_expected", 32'(rd_q.size() != 0), 1);
                    if (rd_q.size() != 0) check("dump_data", out_data, rd_q.pop_front());
                end
                if (done) done_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_addr  = rf_address1;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_wen"}, 32'(rf_writeEn), 0);
        check({tag, "_addrw"}, 32'(rf_addressw), 0);
        check({tag, "_wdata"}, rf_writeData, 0);
        check({tag, "_addr1"}, 32'(rf_address1), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic issue(input bit dump, input int base, input int count);
        int n;
        n = 0;
        cmd_valid = 1; cmd_dump = dump; cmd_base = base[AW-1:0]; cmd_count = count[AW-1:0];
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < TIMEOUT);
        check("cmd_accept", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic feed_word(input int base, input int i, input bit fixed, input int gap);
        logic [BITS-1:0] d;
        int a;
        if (gap > 0) begin
            while ($urandom_range(99) < gap) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
        end
        d = fixed ? (32'hA000_0000 + i) : $urandom;
        a = addr_of(base, i);
        in_valid = 1; in_data = d;
        wr_q.push_back({a[AW-1:0], d});
        model_mem[a] = d;
        // stray commands while busy must be ignored
        cmd_valid = 1'($urandom_range(1)); cmd_dump = 1'($urandom_range(1));
        cmd_base = AW'($urandom_range(15)); cmd_count = AW'($urandom_range(15));
        @(negedge clk);
        check("load_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    // Waits for done while driving out_ready (0 always, 1 period-3, 2 random,
    // 3 low). k = index of the falling edge since the call.
    task automatic wait_done(input string tag, input int mode, input int exp_idx, output int first);
        int k, d0;
        k = 0; first = -1; d0 = done_cnt;
        while (1) begin
            case (mode)
                0: out_ready = 1;
                1: out_ready = (k % 3 == 0);
                2: out_ready = 1'($urandom_range(1));
                default: out_ready = 0;
            endcase
            @(negedge clk);
            if (out_valid && first < 0) first = k;
            if (done || k >= TIMEOUT) break;
            k++;
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(done), 1);
        if (exp_idx >= 0) check({tag, "_done_latency"}, k, exp_idx);
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 0);
        check({tag, "_back_idle"}, 32'(cmd_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input int base, input int count, input bit fixed, input int gap, input int exp_idx);
        int w0, first;
        $display("cmd LOAD base=%0d count=%0d", base, count);
        w0 = wen_cnt;
        issue(0, base, count);
        for (int i = 0; i < count; i++) feed_word(base, i, fixed, gap);
        in_valid = 0; in_data = '0;
        wait_done("load", 3, exp_idx, first);
        check("load_writes", wen_cnt - w0, count);
    endtask

    task automatic run_dump(input int base, input int count, input int mode, input int exp_idx, input int exp_first);
        int h0, v0, first;
        $display("cmd DUMP base=%0d count=%0d ready_mode=%0d", base, count, mode);
        for (int i = 0; i < count; i++) rd_q.push_back(model_mem[addr_of(base, i)]);
        h0 = hs_cnt; v0 = ovalid_cnt;
        issue(1, base, count);
        wait_done("dump", mode, exp_idx, first);
        if (exp_first >= 0) check("dump_first_valid", first, exp_first);
        check("dump_handshakes", hs_cnt - h0, count);
        if (count == 0) check("dump_no_valid", ovalid_cnt - v0, 0);
    endtask

    initial begin
        int w0, d0;
        cmd_valid = 0; cmd_dump = 0; cmd_base = '0; cmd_count = '0;
        in_valid = 0; in_data = '0; out_ready = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = (i == 0) ? '0 : 32'hC0DE_0000 + i;
        repeat (3) @(posedge clk);
        #1 tb_init = 0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 0; mon_en = 1;

        run_load(3, 4, 1, 0, 0);
        run_dump(3, 4, 0, 5, 1);
        run_load(14, 3, 0, 0, 0);
        run_load(0, 1, 0, 0, 0);
        run_dump(14, 3, 1, -1, 1);

        // abort a LOAD after two words
        $display("cmd LOAD base=7 count=5 aborted by reset after 2 words");
        w0 = wen_cnt; d0 = done_cnt;
        issue(0, 7, 5);
        feed_word(7, 0, 0, 0);
        feed_word(7, 1, 0, 0);
        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk); #1;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_writes", wen_cnt - w0, 2);
        check("abort_no_done", done_cnt - d0, 0);
        run_dump(7, 5, 0, 6, 1);

        // zero-length commands
        w0 = wen_cnt;
        run_load(5, 0, 0, 0, 0);
        run_dump(9, 0, 0, 0, -1);
        check("zero_count_no_write", wen_cnt - w0, 0);

        // whole file readback, skipping r0
        run_dump(0, 15, 2, -1, -1);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1) == 1) run_dump($urandom_range(15), $urandom_range(15), 2, -1, -1);
            else run_load($urandom_range(15), $urandom_range(15), 0, 30, -1);
        end
        run_dump(0, 15, 0, 16, 1);

        check("wr_queue_empty", wr_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
